spectrum_bar_meter: RTL and testbench

//  Consumes the complex FFT output stream (AXI-Stream, one bin per beat) and drives
//  NUM_BANDS thermometer LED bars with log-scale levels and per-band peak-hold/decay.

---
 rtl/spectrum_bar_meter.sv | 150 +++++++++++++++
 tb/tb_spectrum_bar_meter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spectrum_bar_meter.sv
// Spectrum bar meter: folds the complex FFT bin stream into NUM_BANDS log-scale
// thermometer bars with per-band peak hold and slow one-LED-at-a-time decay.
module spectrum_bar_meter #(
    parameter int DATA_W       = 16,
    parameter int NFFT_LOG2    = 6,
    parameter int NUM_BANDS    = 4,
    parameter int LED_W        = 4,
    parameter int DECAY_FRAMES = 8
) (
    input  logic                         CLK100MHZ,
    input  logic                         reset_n,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [2*DATA_W-1:0]          s_tdata,
    input  logic                         s_tlast,
    input  logic                         freeze,
    output logic [NUM_BANDS*LED_W-1:0]   led_band,
    output logic                         frame_done,
    output logic                         err_tlast_unexp,
    output logic                         err_tlast_miss
);
    localparam int BIN_N = 2**NFFT_LOG2;
    localparam int NBW   = NFFT_LOG2;
    localparam int BW    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int MAG_W = DATA_W + 1;
    localparam int CW    = $clog2(LED_W + 1);
    localparam int DW    = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

    typedef enum logic {ACCUM = 1'b0, COMMIT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [NBW-1:0]   bin_cnt;
    logic [BW-1:0]    band_sel;
    logic             accept, last_bin, frame_end, commit, in_range;
    logic [DATA_W-1:0] re, im;
    logic [MAG_W-1:0] re_x, im_x, abs_re, abs_im, mag;

    assign re       = s_tdata[DATA_W-1:0];
    assign im       = s_tdata[2*DATA_W-1:DATA_W];
    // Magnitudes are taken one bit wider so |most-negative| is exact
    assign re_x     = {re[DATA_W-1], re};
    assign im_x     = {im[DATA_W-1], im};
    assign abs_re   = re[DATA_W-1] ? -re_x : re_x;
    assign abs_im   = im[DATA_W-1] ? -im_x : im_x;
    assign mag      = abs_re + abs_im;

    assign accept    = s_tvalid & s_tready;
    assign last_bin  = (bin_cnt == NBW'(BIN_N - 1));
    assign frame_end = accept & (s_tlast | last_bin);
    assign commit    = (state == COMMIT);
    // DC and the mirrored upper half carry no extra information
    assign in_range  = ~bin_cnt[NBW-1] & (bin_cnt != '0);

    generate
        if (NUM_BANDS > 1) begin : g_sel
            assign band_sel = bin_cnt[NBW-2 -: BW];
        end else begin : g_sel1
            assign band_sel = '0;
        end
    endgenerate

    // State register
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) state <= ACCUM;
        else          state <= state_nxt;
    end

    // Next state and handshake; COMMIT always lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        s_tready  = 1'b0;
        unique case (state)
            ACCUM: begin
                s_tready = 1'b1;
                if (frame_end) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Bin counter and framing error / frame-done pulses
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt         <= '0;
            err_tlast_unexp <= 1'b0;
            err_tlast_miss  <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            if (frame_end)   bin_cnt <= '0;
            else if (accept) bin_cnt <= bin_cnt + NBW'(1);
            err_tlast_unexp <= frame_end & s_tlast & ~last_bin;
            err_tlast_miss  <= accept & last_bin & ~s_tlast;
            frame_done      <= commit;
        end
    end

    // Per-band accumulate / level / hold / decay
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        logic [MAG_W-1:0] band_max;
        logic [LED_W-1:0] above;
        logic [CW-1:0]    lvl, held, held_nxt;
        logic [DW-1:0]    dcnt, dcnt_nxt;
        logic             upd;

        assign upd = accept & in_range & (band_sel == BW'(b));

        for (genvar k = 0; k < LED_W; k++) begin : g_thr
            localparam logic [MAG_W-1:0] THR = MAG_W'(1) << (DATA_W - LED_W + k);
            assign above[k] = (band_max >= THR);
            assign led_band[b*LED_W + k] = (held > CW'(k));
        end

        // New level and the hold/decay decision taken at commit
        always_comb begin
            lvl = '0;
            for (int k = 0; k < LED_W; k++)
                if (above[k]) lvl = lvl + CW'(1);
            held_nxt = held;
            dcnt_nxt = dcnt;
            if (lvl >= held) begin
                held_nxt = lvl;
                dcnt_nxt = '0;
            end else if (dcnt == DW'(DECAY_FRAMES - 1)) begin
                held_nxt = held - CW'(1);
                dcnt_nxt = '0;
            end else begin
                dcnt_nxt = dcnt + DW'(1);
            end
        end

        // Running maximum over the frame, cleared at every commit
        always_ff @(posedge CLK100MHZ or negedge reset_n) begin
            if (!reset_n)                  band_max <= '0;
            else if (commit)               band_max <= '0;
            else if (upd && mag > band_max) band_max <= mag;
        end

        // Held level; freeze keeps the displayed bar and decay phase untouched
        always_ff @(posedge CLK100MHZ or negedge reset_n) begin
            if (!reset_n) begin
                held <= '0;
                dcnt <= '0;
            end else if (commit && !freeze) begin
                held <= held_nxt;
                dcnt <= dcnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_spectrum_bar_meter.sv
// Directed bench for spectrum_bar_meter (NFFT=64, 4 bands x 4 LEDs, DECAY_FRAMES=2).
module tb_spectrum_bar_meter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_tvalid, s_tready, s_tlast, freeze;
    logic [31:0] s_tdata;
    logic [15:0] led_band;
    logic        frame_done, err_tlast_unexp, err_tlast_miss;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] bre [64];
    logic [15:0] bim [64];
    bit          gap_en = 1'b0;

    spectrum_bar_meter #(
        .DATA_W(16), .NFFT_LOG2(6), .NUM_BANDS(4), .LED_W(4), .DECAY_FRAMES(2)
    ) dut (
        .CLK100MHZ(clk), .reset_n(reset_n), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .freeze(freeze), .led_band(led_band),
        .frame_done(frame_done), .err_tlast_unexp(err_tlast_unexp),
        .err_tlast_miss(err_tlast_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bins();
        for (int i = 0; i < 64; i++) begin
            bre[i] = '0;
            bim[i] = '0;
        end
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One beat; returns 1 ns after the accepting edge
    task automatic beat(input logic [15:0] re, input logic [15:0] im, input logic last);
        if (gap_en) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        s_tdata  = {im, re};
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int n = 0; n < 8 && !s_tready; n++) begin @(posedge clk); #1; end
        if (!s_tready) chk("tready_wait", {31'd0, s_tready}, 32'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic frame(input int last_idx, input logic with_last, input logic [15:0] exp_led,
                         input logic exp_unexp, input logic exp_miss, input string tag);
        for (int i = 0; i <= last_idx; i++)
            beat(bre[i], bim[i], with_last && (i == last_idx));
        chk({tag, "/tready_commit"}, {31'd0, s_tready}, 32'd0);
        chk({tag, "/err_unexp"}, {31'd0, err_tlast_unexp}, {31'd0, exp_unexp});
        chk({tag, "/err_miss"}, {31'd0, err_tlast_miss}, {31'd0, exp_miss});
        chk({tag, "/done_early"}, {31'd0, frame_done}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "/frame_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "/led"}, {16'd0, led_band}, {16'd0, exp_led});
        chk({tag, "/tready_back"}, {31'd0, s_tready}, 32'd1);
        chk({tag, "/err_clear"}, {30'd0, err_tlast_unexp, err_tlast_miss}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] decay_exp [8];
        decay_exp = '{16'h00F0, 16'h0070, 16'h0070, 16'h0030,
                      16'h0030, 16'h0010, 16'h0010, 16'h0000};
        s_tdata = '0;
        freeze  = 1'b0;
        clear_bins();
        do_reset();

        // Reset state
        chk("rst/led", {16'd0, led_band}, 32'd0);
        chk("rst/frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst/tready", {31'd0, s_tready}, 32'd1);
        chk("rst/errs", {30'd0, err_tlast_unexp, err_tlast_miss}, 32'd0);

        // 1: bin 3 at 2^14 -> band0 level 3; DC and mirror bins ignored
        clear_bins();
        bre[3] = 16'h4000; bre[0] = 16'h7FFF; bre[40] = 16'h7FFF;
        frame(63, 1'b1, 16'h0007, 1'b0, 1'b0, "t1");

        // 2: most-negative re/im without wrap, plus intermediate thresholds
        do_reset();
        clear_bins();
        bre[20] = 16'h8000; bim[20] = 16'h8000;   // band2 65536 -> 4
        bre[12] = 16'h1800; bim[12] = 16'h1800;   // band1 12288 -> 2
        bre[28] = 16'hF000;                       // band3 4096  -> 1
        bre[4]  = 16'h0FFF;                       // band0 4095  -> 0
        bre[36] = 16'h8000; bim[36] = 16'h8000;   // mirror, ignored
        frame(63, 1'b1, 16'h1F30, 1'b0, 1'b0, "t2");

        // 3: hold then decay every 2 frames
        do_reset();
        clear_bins();
        bre[9] = 16'h7FFF; bim[9] = 16'h7FFF;
        frame(63, 1'b1, 16'h00F0, 1'b0, 1'b0, "t3_loud");
        clear_bins();
        for (int f = 0; f < 8; f++)
            frame(63, 1'b1, decay_exp[f], 1'b0, 1'b0, $sformatf("t3_decay%0d", f));

        // 4: early tlast, then missing tlast
        do_reset();
        clear_bins();
        bre[2] = 16'h4000;
        frame(10, 1'b1, 16'h0007, 1'b1, 1'b0, "t4_unexp");
        clear_bins();
        bre[0] = 16'h7FFF; bim[0] = 16'h7FFF;     // must land on DC
        frame(63, 1'b0, 16'h0007, 1'b0, 1'b1, "t4_miss");
        clear_bins();
        frame(63, 1'b1, 16'h0003, 1'b0, 1'b0, "t4_after");

        // 5: tvalid gaps and freeze
        do_reset();
        gap_en = 1'b1;
        clear_bins();
        bre[25] = 16'h4000;
        frame(63, 1'b1, 16'h7000, 1'b0, 1'b0, "t5_gap");
        freeze = 1'b1;
        clear_bins();
        bre[10] = 16'h7FFF; bim[10] = 16'h7FFF;
        frame(63, 1'b1, 16'h7000, 1'b0, 1'b0, "t5_frz0");
        clear_bins();
        frame(63, 1'b1, 16'h7000, 1'b0, 1'b0, "t5_frz1");
        frame(63, 1'b1, 16'h7000, 1'b0, 1'b0, "t5_frz2");
        freeze = 1'b0;
        frame(63, 1'b1, 16'h7000, 1'b0, 1'b0, "t5_thaw0");
        frame(63, 1'b1, 16'h3000, 1'b0, 1'b0, "t5_thaw1");
        gap_en = 1'b0;

        // 6: reset in the middle of a loud frame
        do_reset();
        for (int i = 0; i < 64; i++) begin
            bre[i] = 16'h7FFF;
            bim[i] = 16'h7FFF;
        end
        frame(63, 1'b1, 16'hFFFF, 1'b0, 1'b0, "t6_loud");
        for (int i = 0; i < 30; i++) beat(bre[i], bim[i], 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6/rst_led", {16'd0, led_band}, 32'd0);
        chk("t6/rst_done", {31'd0, frame_done}, 32'd0);
        chk("t6/rst_tready", {31'd0, s_tready}, 32'd1);
        chk("t6/rst_errs", {30'd0, err_tlast_unexp, err_tlast_miss}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        clear_bins();
        frame(63, 1'b1, 16'h0000, 1'b0, 1'b0, "t6_silent");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
